// File: rtl/move_collision_checker_pkg.sv
// Shared piece codes, move/reason encodings and FSM states for the move
// collision checker and its shape table.
package move_collision_checker_pkg;

  localparam logic [2:0] PIECE_SQUARE = 3'd0;
  localparam logic [2:0] PIECE_LINE   = 3'd1;
  localparam logic [2:0] PIECE_L      = 3'd2;
  localparam logic [2:0] PIECE_J      = 3'd3;
  localparam logic [2:0] PIECE_S      = 3'd4;
  localparam logic [2:0] PIECE_Z      = 3'd5;
  localparam logic [2:0] PIECE_T      = 3'd6;

  typedef enum logic [1:0] {
    MOVE_DOWN   = 2'b00,
    MOVE_LEFT   = 2'b01,
    MOVE_RIGHT  = 2'b10,
    MOVE_ROTATE = 2'b11
  } move_e;

  typedef enum logic [1:0] {
    REASON_NONE  = 2'b00,
    REASON_WALL  = 2'b01,
    REASON_FLOOR = 2'b10,
    REASON_BLOCK = 2'b11
  } reason_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_valid_piece(input logic [2:0] piece);
    return piece <= PIECE_T;
  endfunction

  // Packs four (dx,dy) cell offsets, cell 0 in the top bits.
  function automatic logic [23:0] cells(input int x0, input int y0,
                                        input int x1, input int y1,
                                        input int x2, input int y2,
                                        input int x3, input int y3);
    return {3'(x0), 3'(y0), 3'(x1), 3'(y1), 3'(x2), 3'(y2), 3'(x3), 3'(y3)};
  endfunction

endpackage

// File: rtl/move_collision_checker_shape_rom.sv
// Piece shape table: cell offsets from the top-left anchor, cells listed
// top row first, left to right. Must stay in step with the renderer.
module move_collision_checker_shape_rom
  import move_collision_checker_pkg::*;
(
  input  logic [2:0]        piece_type,
  input  logic [1:0]        rot,
  input  logic [1:0]        idx,
  output logic signed [2:0] dx,
  output logic signed [2:0] dy
);

  logic [23:0] shape;

  always_comb begin
    shape = '0;
    case (piece_type)
      PIECE_SQUARE: shape = cells(0, 0, 1, 0, 0, -1, 1, -1);
      PIECE_LINE:   shape = rot[0] ? cells(0, 0, 0, -1, 0, -2, 0, -3)
                                   : cells(0, 0, 1, 0, 2, 0, 3, 0);
      PIECE_L: begin
        case (rot)
          2'd0:    shape = cells(0, 0, 0, -1, 0, -2, 1, -2);
          2'd1:    shape = cells(0, 0, 1, 0, 2, 0, 0, -1);
          2'd2:    shape = cells(0, 0, 1, 0, 1, -1, 1, -2);
          default: shape = cells(2, 0, 0, -1, 1, -1, 2, -1);
        endcase
      end
      PIECE_J: begin
        case (rot)
          2'd0:    shape = cells(1, 0, 1, -1, 0, -2, 1, -2);
          2'd1:    shape = cells(0, 0, 0, -1, 1, -1, 2, -1);
          2'd2:    shape = cells(0, 0, 1, 0, 0, -1, 0, -2);
          default: shape = cells(0, 0, 1, 0, 2, 0, 2, -1);
        endcase
      end
      PIECE_S:      shape = rot[0] ? cells(0, 0, 0, -1, 1, -1, 1, -2)
                                   : cells(1, 0, 2, 0, 0, -1, 1, -1);
      PIECE_Z:      shape = rot[0] ? cells(1, 0, 0, -1, 1, -1, 0, -2)
                                   : cells(0, 0, 1, 0, 1, -1, 2, -1);
      PIECE_T: begin
        case (rot)
          2'd0:    shape = cells(0, 0, 1, 0, 2, 0, 1, -1);
          2'd1:    shape = cells(1, 0, 0, -1, 1, -1, 1, -2);
          2'd2:    shape = cells(1, 0, 0, -1, 1, -1, 2, -1);
          default: shape = cells(0, 0, 0, -1, 1, -1, 0, -2);
        endcase
      end
      default:      shape = '0;
    endcase

    case (idx)
      2'd0:    {dx, dy} = shape[23:18];
      2'd1:    {dx, dy} = shape[17:12];
      2'd2:    {dx, dy} = shape[11:6];
      default: {dx, dy} = shape[5:0];
    endcase
  end

endmodule

// File: rtl/move_collision_checker.sv
// Sequential move legality check: one piece cell per cycle against walls,
// floor and a snapshot of the settled-cell map taken at accept.
//
//   state    | meaning
//   ST_IDLE  | ready for a request
//   ST_CHECK | walking piece cells 0..3, leaving early on the first hit
//   ST_DONE  | result held until the consumer takes it
module move_collision_checker
  import move_collision_checker_pkg::*;
#(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int LOC_W   = $clog2(BOARD_W * BOARD_H)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [LOC_W-1:0]           req_loc,
  input  logic [2:0]                 req_type,
  input  logic [1:0]                 req_rot,
  input  logic [1:0]                 req_move,
  input  logic [BOARD_W*BOARD_H-1:0] blocks_exist,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_collide,
  output logic [1:0]                 rsp_reason,
  output logic [LOC_W-1:0]           rsp_loc,
  output logic [1:0]                 rsp_rot
);

  localparam int CELLS = BOARD_W * BOARD_H;
  // Signed widths leave headroom for -1 and for the cell offsets.
  localparam int CW = $clog2(BOARD_W) + 2;
  localparam int RW = $clog2(BOARD_H) + 2;
  localparam logic [LOC_W-1:0]     W_L = LOC_W'(BOARD_W);
  localparam logic signed [CW-1:0] W_S = CW'(BOARD_W);
  localparam logic signed [RW-1:0] H_S = RW'(BOARD_H);

  state_e state, state_nxt;

  logic                 accept;
  logic [CW-2:0]        loc_col_u;
  logic [RW-2:0]        loc_row_u;
  logic signed [CW-1:0] cur_col, nxt_col, cand_col;
  logic signed [RW-1:0] cur_row, nxt_row, cand_row;
  logic [1:0]           nxt_rot, cand_rot;
  logic [2:0]           type_q;
  logic [LOC_W-1:0]     loc_q;
  logic [1:0]           rot_q;
  logic [CELLS-1:0]     snap;
  logic [1:0]           idx;

  logic signed [2:0]    dx, dy;
  logic signed [CW-1:0] cell_col;
  logic signed [RW-1:0] cell_row;
  logic [LOC_W-1:0]     cell_idx;
  logic [LOC_W-1:0]     cand_loc;
  reason_e              cell_reason;
  logic                 cell_fail;

  assign accept = req_valid && req_ready;

  // Decode the flat anchor to (col,row) so moves never wrap across a wall.
  always_comb begin
    loc_col_u = (CW-1)'(req_loc % W_L);
    loc_row_u = (RW-1)'(req_loc / W_L);
    cur_col   = {1'b0, loc_col_u};
    cur_row   = {1'b0, loc_row_u};
    nxt_col   = cur_col;
    nxt_row   = cur_row;
    nxt_rot   = req_rot;
    case (req_move)
      MOVE_DOWN:  nxt_row = cur_row - RW'(1);
      MOVE_LEFT:  nxt_col = cur_col - CW'(1);
      MOVE_RIGHT: nxt_col = cur_col + CW'(1);
      default:    nxt_rot = req_rot + 2'd1;
    endcase
  end

  move_collision_checker_shape_rom u_shape_rom (
    .piece_type (type_q),
    .rot        (cand_rot),
    .idx        (idx),
    .dx         (dx),
    .dy         (dy)
  );

  always_comb begin
    cell_col    = cand_col + {{(CW-3){dx[2]}}, dx};
    cell_row    = cand_row + {{(RW-3){dy[2]}}, dy};
    cell_idx    = LOC_W'(int'(cell_row) * BOARD_W + int'(cell_col));
    cand_loc    = LOC_W'(int'(cand_row) * BOARD_W + int'(cand_col));
    cell_reason = REASON_NONE;
    if (cell_col[CW-1] || cell_col >= W_S) begin
      cell_reason = REASON_WALL;
    end else if (cell_row[RW-1]) begin
      cell_reason = REASON_FLOOR;
    end else if (cell_row >= H_S) begin
      cell_reason = REASON_NONE;
    end else if (snap[cell_idx]) begin
      cell_reason = REASON_BLOCK;
    end
    cell_fail = (cell_reason != REASON_NONE);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_valid) state_nxt = is_valid_piece(req_type) ? ST_CHECK : ST_DONE;
      ST_CHECK: if (cell_fail || idx == 2'd3) state_nxt = ST_DONE;
      ST_DONE:  if (rsp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      type_q      <= '0;
      loc_q       <= '0;
      rot_q       <= '0;
      snap        <= '0;
      cand_col    <= '0;
      cand_row    <= '0;
      cand_rot    <= '0;
      idx         <= '0;
      rsp_collide <= 1'b0;
      rsp_reason  <= REASON_NONE;
      rsp_loc     <= '0;
      rsp_rot     <= '0;
    end else if (accept) begin
      type_q   <= req_type;
      loc_q    <= req_loc;
      rot_q    <= req_rot;
      snap     <= blocks_exist;
      cand_col <= nxt_col;
      cand_row <= nxt_row;
      cand_rot <= nxt_rot;
      idx      <= '0;
      if (!is_valid_piece(req_type)) begin
        rsp_collide <= 1'b1;
        rsp_reason  <= REASON_WALL;
        rsp_loc     <= req_loc;
        rsp_rot     <= req_rot;
      end
    end else if (state == ST_CHECK) begin
      idx <= idx + 2'd1;
      if (cell_fail) begin
        rsp_collide <= 1'b1;
        rsp_reason  <= cell_reason;
        rsp_loc     <= loc_q;
        rsp_rot     <= rot_q;
      end else if (idx == 2'd3) begin
        rsp_collide <= 1'b0;
        rsp_reason  <= REASON_NONE;
        rsp_loc     <= cand_loc;
        rsp_rot     <= cand_rot;
      end
    end
  end

endmodule
